// File: rtl/apb_reg_slave.sv
// APB completer: a window of NUM_REGS read/write registers plus one read-only status word.
// Define APB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states before each access completes.
module apb_reg_slave #(
  parameter logic [15:0] BASE_ADDR   = 16'h0040,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 2,
  localparam int         IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              paddr,
  input  logic                     pwrite,
  input  logic                     psel,
  input  logic                     penable,
  input  logic [15:0]              pwdata,
  output logic [15:0]              prdata,
  output logic                     pready,
  input  logic [15:0]              status_in,
  output logic [16*NUM_REGS-1:0]   reg_q,
  output logic                     wr_strobe,
  output logic [IDX_W-1:0]         wr_index
);

  localparam logic [15:0] NUM_REGS_W = 16'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [15:0]      offset;
  logic             hit_reg;
  logic             hit_status;
  logic [IDX_W-1:0] dec_idx;
  logic [15:0]      rd_data;
  logic             setup;
  logic             access;
  logic             commit;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic             is_reg_q, is_reg_d;
  logic [15:0]      prdata_q, prdata_d;
  logic             pready_q, pready_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [IDX_W-1:0] wr_index_q, wr_index_d;
  logic [15:0]      regs_q [NUM_REGS];
  logic [15:0]      regs_d [NUM_REGS];
`ifdef APB_SLAVE_WAIT_EN
  logic [3:0]       cnt_q, cnt_d;
`endif

  assign setup  = psel & ~penable;
  assign access = psel & penable;

  // Addresses below the base wrap to large offsets and fall into the unmapped range.
  assign offset     = paddr - BASE_ADDR;
  assign hit_reg    = offset < NUM_REGS_W;
  assign hit_status = offset == NUM_REGS_W;
  assign dec_idx    = offset[IDX_W-1:0];

  always_comb begin
    rd_data = 16'h0000;
    if (hit_reg) begin
      rd_data = regs_q[dec_idx];
    end else if (hit_status) begin
      rd_data = status_in;
    end
  end

  assign commit = (state_q == S_ACCESS) & access & write_q & is_reg_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
`ifdef APB_SLAVE_WAIT_EN
          state_d = S_WAIT;
`else
          state_d = S_ACCESS;
`endif
        end
      end
      // ACCESS always lasts one cycle, so pready can never be high twice in a row.
      S_ACCESS: state_d = S_IDLE;
`ifdef APB_SLAVE_WAIT_EN
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (penable && (cnt_q == 4'd1)) begin
          state_d = S_ACCESS;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    idx_d       = idx_q;
    write_d     = write_q;
    is_reg_d    = is_reg_q;
    prdata_d    = prdata_q;
    pready_d    = (state_d == S_ACCESS);
    wr_strobe_d = commit;
    wr_index_d  = commit ? idx_q : wr_index_q;
    regs_d      = regs_q;
`ifdef APB_SLAVE_WAIT_EN
    cnt_d       = cnt_q;
`endif

    if ((state_q == S_IDLE) && setup) begin
      idx_d    = dec_idx;
      write_d  = pwrite;
      is_reg_d = hit_reg;
      prdata_d = pwrite ? 16'h0000 : rd_data;
`ifdef APB_SLAVE_WAIT_EN
      cnt_d    = 4'(WAIT_CYCLES);
`endif
    end
`ifdef APB_SLAVE_WAIT_EN
    if ((state_q == S_WAIT) && access) begin
      cnt_d = cnt_q - 4'd1;
    end
`endif

    // prdata is only non-zero while a read is in flight.
    if (state_d == S_IDLE) begin
      prdata_d = 16'h0000;
    end

    if (commit) begin
      regs_d[idx_q] = pwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      write_q     <= 1'b0;
      is_reg_q    <= 1'b0;
      prdata_q    <= 16'h0000;
      pready_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 16'h0000;
      end
`ifdef APB_SLAVE_WAIT_EN
      cnt_q       <= 4'd0;
`endif
    end else begin
      idx_q       <= idx_d;
      write_q     <= write_d;
      is_reg_q    <= is_reg_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
`ifdef APB_SLAVE_WAIT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[16*g +: 16] = regs_q[g];
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: vector table of single transfers plus
// hand-written abort, back-to-back and mid-transfer reset sequences.
module tb_apb_reg_slave;

  localparam int NUM_REGS = 8;
  localparam int WAIT_CYC = 2;
  localparam int IDX_W    = 3;
`ifdef APB_SLAVE_WAIT_EN
  localparam int EXP_READY = WAIT_CYC + 1;
`else
  localparam int EXP_READY = 1;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [15:0]            paddr;
  logic                   pwrite;
  logic                   psel;
  logic                   penable;
  logic [15:0]            pwdata;
  logic [15:0]            prdata;
  logic                   pready;
  logic [15:0]            status_in;
  logic [16*NUM_REGS-1:0] reg_q;
  logic                   wr_strobe;
  logic [IDX_W-1:0]       wr_index;

  apb_reg_slave #(
    .BASE_ADDR   (16'h0040),
    .NUM_REGS    (NUM_REGS),
    .WAIT_CYCLES (WAIT_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .status_in (status_in),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index)
  );

  // Clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Bus monitor, sampled away from the active edge
  int               strobe_cnt = 0;
  int               ready_cnt  = 0;
  int               consec_err = 0;
  logic [IDX_W-1:0] last_idx   = '0;
  logic             prev_ready = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_idx   <= wr_index;
    end
    if (pready) ready_cnt <= ready_cnt + 1;
    if (pready && prev_ready) consec_err <= consec_err + 1;
    prev_ready <= pready;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives a setup phase now and runs the access phase until pready is seen.
  // Returns one cycle after completion with the bus still driven.
  task automatic apb_run(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         output logic [15:0] rdata, output int cycles, output bit ok);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    cycles = 0; ok = 1'b0; rdata = 16'hxxxx;
    while (!ok && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (pready) begin
        ok = 1'b1;
        rdata = prdata;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] status;
    logic [15:0] exp_rd;
    int          exp_strobes;
    logic [2:0]  exp_idx;
    int          chk_idx;
    logic [15:0] chk_val;
  } vec_t;

  vec_t vecs[21];

  initial begin
    logic [15:0] rd;
    int          cyc;
    bit          ok;

    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b0, 16'h0040 + 16'(i), 16'h0000, 16'h0000, 16'h0000, 0, 3'd0, i, 16'h0000};
    end
    vecs[8]  = '{1'b1, 16'h0043, 16'hA5C3, 16'h0000, 16'h0000, 1, 3'd3, 3, 16'hA5C3};
    vecs[9]  = '{1'b0, 16'h0043, 16'h0000, 16'h0000, 16'hA5C3, 0, 3'd0, 3, 16'hA5C3};
    vecs[10] = '{1'b0, 16'h0048, 16'h0000, 16'h1234, 16'h1234, 0, 3'd0, 3, 16'hA5C3};
    vecs[11] = '{1'b1, 16'h0048, 16'hFFFF, 16'h1234, 16'h0000, 0, 3'd0, 3, 16'hA5C3};
    vecs[12] = '{1'b1, 16'h003F, 16'hBEEF, 16'h1234, 16'h0000, 0, 3'd0, 7, 16'h0000};
    vecs[13] = '{1'b1, 16'h0049, 16'hBEEF, 16'h1234, 16'h0000, 0, 3'd0, 0, 16'h0000};
    vecs[14] = '{1'b0, 16'h0049, 16'h0000, 16'h1234, 16'h0000, 0, 3'd0, 0, 16'h0000};
    vecs[15] = '{1'b1, 16'h0040, 16'h1111, 16'h1234, 16'h0000, 1, 3'd0, 0, 16'h1111};
    vecs[16] = '{1'b1, 16'h0047, 16'h7777, 16'h1234, 16'h0000, 1, 3'd7, 7, 16'h7777};
    vecs[17] = '{1'b0, 16'h0040, 16'h0000, 16'h1234, 16'h1111, 0, 3'd0, 0, 16'h1111};
    vecs[18] = '{1'b0, 16'h003F, 16'h0000, 16'h1234, 16'h0000, 0, 3'd0, 3, 16'hA5C3};
    vecs[19] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1234, 16'h0000, 0, 3'd0, 7, 16'h7777};
    vecs[20] = '{1'b0, 16'h0048, 16'h0000, 16'hBEEF, 16'hBEEF, 0, 3'd0, 0, 16'h1111};

    // Reset
    reset = 1'b1; status_in = 16'h0000; paddr = 16'h0000; pwdata = 16'h0000;
    bus_idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_pready", 128'(pready), 128'(1'b0));
    check("reset_prdata", 128'(prdata), 128'(16'h0000));
    check("reset_reg_q", 128'(reg_q), 128'(0));
    check("reset_wr_strobe", 128'(wr_strobe), 128'(1'b0));
    check("reset_wr_index", 128'(wr_index), 128'(3'd0));
    @(posedge clk); #1;

    // Vector table
    for (int v = 0; v < 21; v++) begin
      status_in  = vecs[v].status;
      strobe_cnt = 0;
      ready_cnt  = 0;
      apb_run(vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, cyc, ok);
      bus_idle();
      @(posedge clk); #1;
      check($sformatf("v%0d_done", v), 128'(ok), 128'(1'b1));
      check($sformatf("v%0d_rdata", v), 128'(rd), 128'(vecs[v].exp_rd));
      check($sformatf("v%0d_latency", v), 128'(cyc), 128'(EXP_READY));
      check($sformatf("v%0d_ready_cnt", v), 128'(ready_cnt), 128'(1));
      check($sformatf("v%0d_strobes", v), 128'(strobe_cnt), 128'(vecs[v].exp_strobes));
      if (vecs[v].exp_strobes > 0)
        check($sformatf("v%0d_wr_index", v), 128'(last_idx), 128'(vecs[v].exp_idx));
      check($sformatf("v%0d_reg", v), 128'(reg_q[16*vecs[v].chk_idx +: 16]), 128'(vecs[v].chk_val));
      check($sformatf("v%0d_prdata_idle", v), 128'(prdata), 128'(16'h0000));
    end
    check("reg_q_all", 128'(reg_q),
          {16'h7777, 16'h0000, 16'h0000, 16'h0000, 16'hA5C3, 16'h0000, 16'h0000, 16'h1111});

    // Abort: psel dropped right after the setup phase of a write
    strobe_cnt = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0043; pwdata = 16'h0F0F;
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_pready", 128'(pready), 128'(1'b0));
    @(posedge clk); #1;
    check("abort_strobes", 128'(strobe_cnt), 128'(0));
    check("abort_reg3", 128'(reg_q[63:48]), 128'(16'hA5C3));
    apb_run(1'b0, 16'h0043, 16'h0000, rd, cyc, ok);
    bus_idle();
    @(posedge clk); #1;
    check("after_abort_done", 128'(ok), 128'(1'b1));
    check("after_abort_rdata", 128'(rd), 128'(16'hA5C3));

    // Back-to-back: the read setup overlaps the write strobe cycle
    strobe_cnt = 0;
    apb_run(1'b1, 16'h0041, 16'h2222, rd, cyc, ok);
    apb_run(1'b0, 16'h0041, 16'h0000, rd, cyc, ok);
    bus_idle();
    @(posedge clk); #1;
    check("b2b_done", 128'(ok), 128'(1'b1));
    check("b2b_latency", 128'(cyc), 128'(EXP_READY));
    check("b2b_rdata", 128'(rd), 128'(16'h2222));
    check("b2b_strobes", 128'(strobe_cnt), 128'(1));
    check("b2b_wr_index", 128'(last_idx), 128'(3'd1));

    // Reset asserted during the first access/wait cycle of a write
    strobe_cnt = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0042; pwdata = 16'h3333;
    @(posedge clk); #1;
    penable = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_idle();
    @(negedge clk);
    check("rst_mid_pready", 128'(pready), 128'(1'b0));
    check("rst_mid_reg_q", 128'(reg_q), 128'(0));
    check("rst_mid_prdata", 128'(prdata), 128'(16'h0000));
    @(posedge clk); #1;
    check("rst_mid_strobes", 128'(strobe_cnt), 128'(0));
    apb_run(1'b0, 16'h0042, 16'h0000, rd, cyc, ok);
    bus_idle();
    @(posedge clk); #1;
    check("after_rst_done", 128'(ok), 128'(1'b1));
    check("after_rst_rdata", 128'(rd), 128'(16'h0000));

    check("pready_never_consecutive", 128'(consec_err), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
